// File: rtl/arb8_2ch.sv
// Two-requester round-robin arbiter with bounded bursts feeding a single
// registered 8-bit output stage with valid/ready flow control.
module arb8_2ch #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_src,
    input  logic       o_ready,
    output logic       sel
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GA     = 2'd1;
    localparam logic [1:0] ST_GB     = 2'd2;
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       o_valid_q, o_valid_d;
    logic [7:0] o_data_q, o_data_d;
    logic       o_src_q, o_src_d;

    logic       load_en_s;
    logic       a_acc_s;
    logic       b_acc_s;
    logic [3:0] cnt_inc_s;

    assign load_en_s = !o_valid_q || o_ready;
    assign a_ready   = (state_q == ST_GA) && load_en_s;
    assign b_ready   = (state_q == ST_GB) && load_en_s;
    assign a_acc_s   = a_valid && a_ready;
    assign b_acc_s   = b_valid && b_ready;
    assign cnt_inc_s = cnt_q + 4'd1;

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_src   = o_src_q;
    assign sel     = (state_q == ST_GB);

    // Grant FSM: everything freezes while the output stage is stalled
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (load_en_s) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 4'd0;
                    if (a_valid && b_valid) begin
                        // last_q = 1 means B was served last, so A wins the tie
                        state_d = last_q ? ST_GA : ST_GB;
                    end else if (a_valid) begin
                        state_d = ST_GA;
                    end else if (b_valid) begin
                        state_d = ST_GB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GA: begin
                    if (!a_valid) begin
                        state_d = b_valid ? ST_GB : ST_IDLE;
                        last_d  = 1'b0;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc_s == BURST_LIM) begin
                        cnt_d = 4'd0;
                        if (b_valid) begin
                            state_d = ST_GB;
                            last_d  = 1'b0;
                        end else begin
                            state_d = ST_GA;
                        end
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_GB: begin
                    if (!b_valid) begin
                        state_d = a_valid ? ST_GA : ST_IDLE;
                        last_d  = 1'b1;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc_s == BURST_LIM) begin
                        cnt_d = 4'd0;
                        if (a_valid) begin
                            state_d = ST_GA;
                            last_d  = 1'b1;
                        end else begin
                            state_d = ST_GB;
                        end
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output stage: load on accept, drain to empty when nothing new arrives
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_src_d   = o_src_q;
        if (a_acc_s) begin
            o_valid_d = 1'b1;
            o_data_d  = a_data;
            o_src_d   = 1'b0;
        end else if (b_acc_s) begin
            o_valid_d = 1'b1;
            o_data_d  = b_data;
            o_src_d   = 1'b1;
        end else if (load_en_s) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            cnt_q     <= 4'd0;
            o_valid_q <= 1'b0;
            o_data_q  <= 8'h00;
            o_src_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_src_q   <= o_src_d;
        end
    end

endmodule

// File: tb/tb_arb8_2ch.sv
// Directed and scoreboard bench for arb8_2ch: burst alternation, backpressure,
// valid drop, reset mid-burst and a randomized ordering/fairness run.
module tb_arb8_2ch;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_src;
    logic       o_ready;
    logic       sel;

    int total;
    int bad;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         na;
    int         nb;
    int         max_na;
    int         max_nb;

    arb8_2ch #(.MAX_BURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_src   (o_src),
        .o_ready (o_ready),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic v, input logic [7:0] d,
                         input logic s, input logic sl);
        chk({tag, "_valid"}, o_valid, v);
        chk({tag, "_data"}, o_data, d);
        chk({tag, "_src"}, o_src, s);
        chk({tag, "_sel"}, sel, sl);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one random-phase cycle: drive, then score what the next edge will do
    task automatic rnd_step(input bit drive_rand);
        logic [7:0] exp;
        if (drive_rand) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            a_data  = 8'($urandom_range(0, 255));
            b_data  = 8'($urandom_range(0, 255));
            o_ready = ($urandom_range(0, 3) != 0);
        end else begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            o_ready = 1'b1;
        end
        #1;
        if (o_valid && o_ready) begin
            if (o_src == 1'b0) begin
                chk("rnd_qa_nonempty", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) begin
                    exp = qa.pop_front();
                    chk("rnd_a_order", o_data, exp);
                end
            end else begin
                chk("rnd_qb_nonempty", 32'(qb.size() > 0), 32'd1);
                if (qb.size() > 0) begin
                    exp = qb.pop_front();
                    chk("rnd_b_order", o_data, exp);
                end
            end
        end
        if (a_valid && a_ready) qa.push_back(a_data);
        if (b_valid && b_ready) qb.push_back(b_data);
        if (!b_valid || (b_valid && b_ready)) na = 0;
        else if (a_valid && a_ready) na++;
        if (!a_valid || (a_valid && a_ready)) nb = 0;
        else if (b_valid && b_ready) nb++;
        if (na > max_na) max_na = na;
        if (nb > max_nb) max_nb = nb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        na      = 0;
        nb      = 0;
        max_na  = 0;
        max_nb  = 0;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = 8'h00;
        b_data  = 8'h00;
        o_ready = 1'b1;

        // reset state
        cyc();
        cyc();
        chk_o("rst", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_ardy", a_ready, 1'b0);
        chk("rst_brdy", b_ready, 1'b0);

        // both valid: A first, alternating every 4 beats
        rst_n   = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h32;
        b_data  = 8'h25;
        #1;
        chk("idle_ardy", a_ready, 1'b0);
        chk("idle_brdy", b_ready, 1'b0);
        cyc();
        chk_o("grantA", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("grantA_ardy", a_ready, 1'b1);
        chk("grantA_brdy", b_ready, 1'b0);
        for (int k = 0; k < 16; k++) begin
            logic grp_b;
            logic sel_e;
            grp_b = ((k / 4) % 2) == 1;
            sel_e = (((k + 1) / 4) % 2) == 1;
            cyc();
            chk_o("alt", 1'b1, grp_b ? 8'h25 : 8'h32, grp_b, sel_e);
            chk("alt_ardy", a_ready, !sel_e);
            chk("alt_brdy", b_ready, sel_e);
        end

        // only A valid: GA held, one beat per cycle through cnt wrap
        b_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_data = 8'(8'h40 + i);
            cyc();
            chk_o("onlyA", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            chk("onlyA_ardy", a_ready, 1'b1);
        end

        // backpressure mid-burst; cnt is 3 after this beat
        a_data = 8'h60;
        cyc();
        chk_o("bp_pre", 1'b1, 8'h60, 1'b0, 1'b0);
        o_ready = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'h70;
        a_data  = 8'h61;
        #1;
        chk("bp_ardy0", a_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_o("bp", 1'b1, 8'h60, 1'b0, 1'b0);
            chk("bp_ardy", a_ready, 1'b0);
            chk("bp_brdy", b_ready, 1'b0);
        end
        o_ready = 1'b1;
        cyc();
        chk_o("bp_resume", 1'b1, 8'h61, 1'b0, 1'b1);
        cyc();
        chk_o("bp_b", 1'b1, 8'h70, 1'b1, 1'b1);

        // back to A, then A drops valid after 2 beats while B waits
        b_valid = 1'b0;
        cyc();
        chk_o("toA", 1'b0, 8'h70, 1'b1, 1'b0);
        a_data  = 8'h80;
        b_valid = 1'b1;
        b_data  = 8'h90;
        cyc();
        chk_o("drop_a0", 1'b1, 8'h80, 1'b0, 1'b0);
        a_data = 8'h81;
        cyc();
        chk_o("drop_a1", 1'b1, 8'h81, 1'b0, 1'b0);
        a_valid = 1'b0;
        cyc();
        chk_o("dropA", 1'b0, 8'h81, 1'b0, 1'b1);
        chk("dropA_brdy", b_ready, 1'b1);
        cyc();
        chk_o("dropA_b", 1'b1, 8'h90, 1'b1, 1'b1);

        // round robin through IDLE: last=A means the next tie goes to B
        b_valid = 1'b0;
        cyc();
        chk_o("rr_idle", 1'b0, 8'h90, 1'b1, 1'b0);
        a_valid = 1'b1;
        a_data  = 8'hA0;
        cyc();
        chk_o("rr_ga", 1'b0, 8'h90, 1'b1, 1'b0);
        cyc();
        chk_o("rr_a0", 1'b1, 8'hA0, 1'b0, 1'b0);
        a_valid = 1'b0;
        cyc();
        chk_o("rr_idle2", 1'b0, 8'hA0, 1'b0, 1'b0);
        chk("rr_idle2_ardy", a_ready, 1'b0);
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'hA1;
        b_data  = 8'hB1;
        cyc();
        chk_o("rr_tieB", 1'b0, 8'hA0, 1'b0, 1'b1);
        chk("rr_tieB_ardy", a_ready, 1'b0);
        chk("rr_tieB_brdy", b_ready, 1'b1);
        cyc();
        chk_o("rr_b1", 1'b1, 8'hB1, 1'b1, 1'b1);
        b_valid = 1'b0;
        cyc();
        chk_o("rr_backA", 1'b0, 8'hB1, 1'b1, 1'b0);
        chk("rr_backA_ardy", a_ready, 1'b1);

        // reset in the middle of a B burst
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'hC0;
        cyc();
        chk("mid_gb_sel", sel, 1'b1);
        cyc();
        chk_o("mid_c0", 1'b1, 8'hC0, 1'b1, 1'b1);
        b_data = 8'hC1;
        cyc();
        chk_o("mid_c1", 1'b1, 8'hC1, 1'b1, 1'b1);
        rst_n = 1'b0;
        cyc();
        chk_o("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_mid_brdy", b_ready, 1'b0);
        rst_n   = 1'b1;
        a_valid = 1'b1;
        #1;
        chk("post_rst_ardy", a_ready, 1'b0);
        chk("post_rst_brdy", b_ready, 1'b0);
        cyc();
        chk("post_rst_tie_sel", sel, 1'b0);
        chk("post_rst_tie_ardy", a_ready, 1'b1);

        // randomized scoreboard run, then drain
        qa.delete();
        qb.delete();
        for (int i = 0; i < 1000; i++) rnd_step(1'b1);
        for (int i = 0; i < 8; i++) rnd_step(1'b0);
        chk("rnd_qa_drained", 32'(qa.size()), 32'd0);
        chk("rnd_qb_drained", 32'(qb.size()), 32'd0);
        chk("rnd_fair_a", 32'(max_na <= 4), 32'd1);
        chk("rnd_fair_b", 32'(max_nb <= 4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb8_2ch.md
# arb8_2ch

Round-robin arbiter that shares one 8-bit output channel between two valid/ready requesters (A and B). It sits in front of the 2-channel 8-bit mux datapath: it drives the mux select, grants one requester at a time with bounded bursts, and registers the selected byte into a single output stage with valid/ready flow control.

## Interface
- MAX_BURST, 4, maximum beats accepted from one requester per grant while the other is requesting; legal range 1..15.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- a_valid  input  1  requester A has a byte.
- a_data  input  8  requester A byte.
- a_ready  output  1  A beat accepted this cycle when a_valid && a_ready.
- b_valid  input  1  requester B has a byte.
- b_data  input  8  requester B byte.
- b_ready  output  1  B beat accepted this cycle when b_valid && b_ready.
- o_valid  output  1  output register holds a byte.
- o_data  output  8  output byte.
- o_src  output  1  source of o_data: 0 = A, 1 = B.
- o_ready  input  1  downstream accepts o_data when o_valid && o_ready.
- sel  output  1  mux select, registered: 0 = A, 1 = B; equals 1 only in state GB.

## Operation
- States: IDLE, GA (A granted), GB (B granted). Registers: state, last (last granted requester), cnt (4 bits, beats in current grant), output register.
- load_en = !o_valid || o_ready. a_ready = (state==GA) && load_en; b_ready = (state==GB) && load_en. Neither ready in IDLE.
- Accepted beat: o_data <= granted data, o_src <= granted id, o_valid <= 1, cnt <= cnt+1. If load_en && no accept: o_valid <= 0.
- IDLE: only a_valid -> GA; only b_valid -> GB; both -> the one != last; neither -> stay. cnt <= 0 on every grant entry.
- GA leaves at the clock edge when (a_valid low) or (accept making cnt==MAX_BURST and b_valid high): -> GB if b_valid, else IDLE; last <= A. At cnt==MAX_BURST with b_valid low: stay GA, cnt <= 0.
- GB symmetric with A/B swapped.
- a_valid dropping in GA with b_valid low -> IDLE, not directly re-granted until next cycle decision.
- Data never lost or duplicated: every accepted beat appears exactly once on o_data, in acceptance order.
- a_data/b_data only sampled on accept; ungranted data ignored.

## Timing
- Reset (rst_n low at edge): state IDLE, last = B (A wins first tie), cnt 0, o_valid 0, o_data 8'h00, o_src 0, sel 0; a_ready, b_ready 0 during and first cycle after reset. Reset mid-burst discards any held output byte.
- Grant latency: valid asserted in IDLE at edge N -> ready high in cycle N+1.
- Data latency: accept at edge N -> o_valid/o_data visible after edge N (1 cycle).
- Throughput: 1 beat/cycle with o_ready held high; handover between requesters costs 0 cycles (GA->GB direct), IDLE entry costs 1.
- Backpressure: o_ready low with o_valid high -> both readies low, o_data/o_src stable, state and cnt frozen.
- Simultaneous o_ready and new accept in same cycle: output register replaced, no bubble.
- cnt never exceeds MAX_BURST; wraps to 0 on re-grant.

## Test plan
- Reset then both valid, A=8'h32, B=8'h25, o_ready=1 -> first grant A; 4 beats 8'h32 o_src=0, then 4 beats 8'h25 o_src=1, alternating every 4 beats; sel tracks state.
- Only A valid for 10 cycles, MAX_BURST=4 -> GA held, 10 consecutive beats, no IDLE gaps, cnt wraps at 4.
- o_ready low 3 cycles mid-burst with o_valid high -> o_data stable, a_ready=b_ready=0, cnt frozen; resumes with no lost/duplicate byte.
- A drops valid after 2 beats while B valid -> switch to GB next cycle, last=A; next tie goes to B... then A per round-robin.
- rst_n low for 1 cycle mid-burst of B -> o_valid 0, o_data 8'h00, sel 0, state IDLE; subsequent tie granted to A.
- Scoreboard random valid/ready 1000 cycles -> per-source order preserved, no beat lost, no starvation beyond MAX_BURST beats of the other source.
